// File: rtl/lsu_pkg.sv
// lsu_pkg: shared states, funct3/error encodings and command decode helpers for the LSU.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        return is_store ? !(f3 inside {F3_B, F3_H, F3_W})
                        : !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3 == F3_H || f3 == F3_HU) && a[0]) || (f3 == F3_W && a != 2'b00);
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        return (f3 == F3_W) ? 4'b1111 : ((f3[0] ? 4'b0011 : 4'b0001) << a);
    endfunction

    // Sub-word stores replicate the datum into every lane so the slave picks it via byte enables.
    function automatic logic [31:0] wdata_rep(input logic [2:0] f3, input logic [31:0] d);
        return f3[1] ? d : f3[0] ? {2{d[15:0]}} : {4{d[7:0]}};
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/half of a read word and sign/zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(i_rdata >> {i_addr_lo, 3'b000});
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = (i_funct3 == F3_B)  ? {{24{w_byte[7]}}, w_byte} :
                 (i_funct3 == F3_BU) ? {24'd0, w_byte} :
                 (i_funct3 == F3_H)  ? {{16{w_half[15]}}, w_half} :
                 (i_funct3 == F3_HU) ? {16'd0, w_half} : i_rdata;
    end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator on a req/gnt/rvalid word bus.
// Define LSU_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYCLES with error code 11.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
`ifdef LSU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ls_valid,
    output logic              ls_ready,
    input  logic              ls_is_store,
    input  logic [2:0]        ls_funct3,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    output logic              ls_err,
    output logic [1:0]        ls_err_code,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    state_t            r_state;
    logic              r_ready;
    logic              r_done;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [1:0]        r_code;
    logic              r_req;
    logic              r_we;
    logic [3:0]        r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_store;
    logic [2:0]        r_f3;
    logic [1:0]        r_addr_lo;
    logic [31:0]       w_load;
    logic              w_illegal;
    logic              w_misalign;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_tcnt;
`endif

    assign w_illegal  = f3_illegal(ls_is_store, ls_funct3);
    assign w_misalign = misaligned(ls_funct3, ls_addr[1:0]);

    lsu_load_align u_align (
        .i_rdata   (mem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_f3),
        .o_data    (w_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_code    <= ERR_NONE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_store   <= 1'b0;
            r_f3      <= '0;
            r_addr_lo <= '0;
`ifdef LSU_TIMEOUT_EN
            r_tcnt    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (ls_valid) begin
                        r_store   <= ls_is_store;
                        r_f3      <= ls_funct3;
                        r_addr_lo <= ls_addr[1:0];
                        r_ready   <= 1'b0;
                        if (w_illegal || w_misalign) begin
                            r_state <= RESP;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_code  <= w_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                            r_rdata <= '0;
                        end else begin
                            r_state <= REQ;
                            r_req   <= 1'b1;
                            r_we    <= ls_is_store;
                            r_be    <= byte_en(ls_funct3, ls_addr[1:0]);
                            r_addr  <= {ls_addr[ADDR_W-1:2], 2'b00};
                            r_wdata <= ls_is_store ? wdata_rep(ls_funct3, ls_wdata) : '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        r_state <= WAIT;
                        r_req   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                        r_tcnt  <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        r_state <= RESP;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                        r_code  <= ERR_NONE;
                        r_rdata <= r_store ? '0 : w_load;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= RESP;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_code  <= ERR_TIMEOUT;
                        r_rdata <= '0;
                    end else begin
                        r_tcnt  <= r_tcnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ls_ready    = r_ready;
    assign ls_done     = r_done;
    assign ls_rdata    = r_rdata;
    assign ls_err      = r_err;
    assign ls_err_code = r_code;
    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_be      = r_be;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;

endmodule
